// File: rtl/hazard_controller_if.sv
// Handshake bundle between the uDLX pipeline datapath and its hazard controller.
// The master is the pipeline (drives decoded ID controls, branch and memory
// status); the slave is the hazard controller (drives stall/flush/forward).
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1;
  logic                      id_rd_en1;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2;
  logic                      id_rd_en2;
  logic [REG_ADDR_WIDTH-1:0] id_wr_addr;
  logic                      id_wr_en;
  logic                      id_mem_rd_en;
  logic                      ex_branch_taken;
  logic                      mem_stall;
  logic                      stall_if_id;
  logic                      bubble_ex;
  logic                      flush_if_id;
  logic [1:0]                fwd_a_sel;
  logic [1:0]                fwd_b_sel;

  modport master (
    output id_valid, id_rd_addr1, id_rd_en1, id_rd_addr2, id_rd_en2,
           id_wr_addr, id_wr_en, id_mem_rd_en, ex_branch_taken, mem_stall,
    input  stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rd_addr1, id_rd_en1, id_rd_addr2, id_rd_en2,
           id_wr_addr, id_wr_en, id_mem_rd_en, ex_branch_taken, mem_stall,
    output stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the uDLX ID/EX/MEM/WB pipeline.
// Shadows the register-write intent of the instructions in EX, MEM and WB,
// and from that derives load-use stalls, taken-branch flush bubbles,
// memory-wait freezes and EX operand forwarding selects.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic              clk,
  input  logic              rst,
  hazard_controller_if.slave bus
);

  localparam int AW = REG_ADDR_WIDTH;
  localparam logic [2:0] PEN_RELOAD = 3'(BRANCH_PENALTY - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;

  // EX shadow slot
  logic          r_ex_vld;
  logic          r_ex_we;
  logic [AW-1:0] r_ex_wa;
  logic          r_ex_ld;
  logic [AW-1:0] r_ex_s1;
  logic          r_ex_e1;
  logic [AW-1:0] r_ex_s2;
  logic          r_ex_e2;
  // MEM shadow slot
  logic          r_mem_vld;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_wa;
  // WB shadow slot
  logic          r_wb_vld;
  logic          r_wb_we;
  logic [AW-1:0] r_wb_wa;

  logic          w_load_use;
  logic          w_stall;
  logic          w_bubble;
  logic          w_flush;

  // A slot writes r only when it really commits a write to a non-zero register.
  function automatic logic writes_reg(input logic vld, input logic we,
                                      input logic [AW-1:0] wa,
                                      input logic [AW-1:0] r);
    return vld & we & (wa == r) & (r != '0);
  endfunction

  // MEM result is younger than WB, so it wins when both write the source.
  function automatic logic [1:0] fwd_select(input logic [AW-1:0] src,
                                            input logic en);
    if (!r_ex_vld || !en)                           return 2'b00;
    else if (writes_reg(r_mem_vld, r_mem_we, r_mem_wa, src)) return 2'b01;
    else if (writes_reg(r_wb_vld, r_wb_we, r_wb_wa, src))    return 2'b10;
    else                                            return 2'b00;
  endfunction

  assign w_load_use = bus.id_valid & r_ex_ld &
                      ((bus.id_rd_en1 & writes_reg(r_ex_vld, r_ex_we, r_ex_wa, bus.id_rd_addr1)) |
                       (bus.id_rd_en2 & writes_reg(r_ex_vld, r_ex_we, r_ex_wa, bus.id_rd_addr2)));

  // State register: flush FSM and remaining-penalty counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: memory wait freezes everything, a taken branch opens a flush window
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.mem_stall) begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_branch_taken && (BRANCH_PENALTY > 1)) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = PEN_RELOAD;
          end
        end
        ST_FLUSH: begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Outputs: prioritised memory wait, branch, flush window, load-use
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (bus.mem_stall) begin
      w_stall = 1'b1;
    end else if ((r_state == ST_RUN) && bus.ex_branch_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_load_use) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  assign bus.stall_if_id = w_stall;
  assign bus.bubble_ex   = w_bubble;
  assign bus.flush_if_id = w_flush;
  assign bus.fwd_a_sel   = fwd_select(r_ex_s1, r_ex_e1);
  assign bus.fwd_b_sel   = fwd_select(r_ex_s2, r_ex_e2);

  // ---- ID -> EX -> MEM -> WB boundary: slot valid bits (reset-controlled) ----
  // Slot valids advance on every non-frozen edge; a bubble or idle ID lands as invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      r_wb_vld  <= 1'b0;
    end else if (!bus.mem_stall) begin
      r_wb_vld  <= r_mem_vld;
      r_mem_vld <= r_ex_vld;
      r_ex_vld  <= bus.id_valid & ~w_bubble;
    end
  end

  // ---- ID -> EX -> MEM -> WB boundary: slot payload (qualified by valid) ----
  // Slot payload follows the valids; contents of an invalid slot are don't-care
  always_ff @(posedge clk) begin
    if (!bus.mem_stall) begin
      r_wb_we  <= r_mem_we;
      r_wb_wa  <= r_mem_wa;
      r_mem_we <= r_ex_we;
      r_mem_wa <= r_ex_wa;
      r_ex_we  <= bus.id_wr_en;
      r_ex_wa  <= bus.id_wr_addr;
      r_ex_ld  <= bus.id_mem_rd_en;
      r_ex_s1  <= bus.id_rd_addr1;
      r_ex_e1  <= bus.id_rd_en1;
      r_ex_s2  <= bus.id_rd_addr2;
      r_ex_e2  <= bus.id_rd_en2;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed pipeline scenarios followed by random
// traffic, all compared against an instruction-level model of the pipeline.
module tb_hazard_controller;
  localparam int AW = 5;
  localparam int BP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_ADDR_WIDTH(AW)) bus ();

  hazard_controller #(.REG_ADDR_WIDTH(AW), .BRANCH_PENALTY(BP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v; bit we; int wa; bit ld; int s1; bit e1; int s2; bit e2;
  } ins_t;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; bub_left = flush cycles still owed
  ins_t pipe [3];
  int   bub_left;
  ins_t cur_id;
  bit   cur_br, cur_ms, cur_rst;
  bit   e_bub;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  function automatic ins_t nop();
    ins_t x;
    x = '{default: 0};
    return x;
  endfunction

  function automatic ins_t mk(int s1, bit e1, int s2, bit e2, int wa, bit we, bit ld);
    ins_t x;
    x = '{v: 1, we: we, wa: wa, ld: ld, s1: s1, e1: e1, s2: s2, e2: e2};
    return x;
  endfunction

  function automatic bit wr(ins_t x, int r);
    return x.v && x.we && (x.wa == r) && (r != 0);
  endfunction

  function automatic int fsel(int s, bit e);
    if (!pipe[0].v || !e) return 0;
    if (wr(pipe[1], s))   return 1;
    if (wr(pipe[2], s))   return 2;
    return 0;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs mid-cycle and compare all outputs to the model
  task automatic drive(ins_t i, bit br, bit ms, bit r);
    bit e_st, e_fl, lu;
    @(negedge clk);
    cur_id = i; cur_br = br; cur_ms = ms; cur_rst = r;
    rst                 = r;
    bus.id_valid        = i.v;
    bus.id_rd_addr1     = AW'(i.s1);
    bus.id_rd_en1       = i.e1;
    bus.id_rd_addr2     = AW'(i.s2);
    bus.id_rd_en2       = i.e2;
    bus.id_wr_addr      = AW'(i.wa);
    bus.id_wr_en        = i.we;
    bus.id_mem_rd_en    = i.ld;
    bus.ex_branch_taken = br;
    bus.mem_stall       = ms;
    #1;
    e_st = 0; e_bub = 0; e_fl = 0;
    lu = i.v && pipe[0].ld && ((i.e1 && wr(pipe[0], i.s1)) || (i.e2 && wr(pipe[0], i.s2)));
    if (ms) e_st = 1;
    else if (bub_left > 0 || br) begin e_fl = 1; e_bub = 1; end
    else if (lu) begin e_st = 1; e_bub = 1; end
    chk("stall_if_id", 8'(bus.stall_if_id), 8'(e_st));
    chk("bubble_ex",   8'(bus.bubble_ex),   8'(e_bub));
    chk("flush_if_id", 8'(bus.flush_if_id), 8'(e_fl));
    chk("fwd_a_sel",   8'(bus.fwd_a_sel),   8'(fsel(pipe[0].s1, pipe[0].e1)));
    chk("fwd_b_sel",   8'(bus.fwd_b_sel),   8'(fsel(pipe[0].s2, pipe[0].e2)));
  endtask

  // Advance the model across the clock edge
  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = nop();
      bub_left = 0;
    end else if (!cur_ms) begin
      if (bub_left > 0) bub_left--;
      else if (cur_br)  bub_left = BP - 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (e_bub || !cur_id.v) ? nop() : cur_id;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin drive(nop(), 0, 0, 0); tick(); end
  endtask

  initial begin
    ins_t rd;
    for (int k = 0; k < 3; k++) pipe[k] = nop();
    bub_left = 0;
    rst = 1'b1;

    // Reset and reset state
    drive(nop(), 0, 0, 1); tick();
    drive(nop(), 0, 0, 1); tick();
    drive(nop(), 0, 0, 0);
    chk("rst_stall", 8'(bus.stall_if_id), 8'd0);
    chk("rst_bubble", 8'(bus.bubble_ex), 8'd0);
    chk("rst_flush", 8'(bus.flush_if_id), 8'd0);
    chk("rst_fwd_a", 8'(bus.fwd_a_sel), 8'd0);
    tick();

    // Forwarding chain: ADD r3; ADD r4=r3+r3; SUB r5=r3+r4
    drive(mk(1, 1, 2, 1, 3, 1, 0), 0, 0, 0); tick();
    drive(mk(3, 1, 3, 1, 4, 1, 0), 0, 0, 0);
    chk("chain_nostall", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(mk(3, 1, 4, 1, 5, 1, 0), 0, 0, 0);
    chk("chain_c2_fa", 8'(bus.fwd_a_sel), 8'd1);
    chk("chain_c2_fb", 8'(bus.fwd_b_sel), 8'd1);
    tick();
    drive(nop(), 0, 0, 0);
    chk("chain_c3_fa", 8'(bus.fwd_a_sel), 8'd2);
    chk("chain_c3_fb", 8'(bus.fwd_b_sel), 8'd1);
    tick();
    drain();

    // Load-use: LW r2; ADD r6=r2+r1
    drive(mk(1, 1, 0, 0, 2, 1, 1), 0, 0, 0); tick();
    rd = mk(2, 1, 1, 1, 6, 1, 0);
    drive(rd, 0, 0, 0);
    chk("lu_stall", 8'(bus.stall_if_id), 8'd1);
    chk("lu_bubble", 8'(bus.bubble_ex), 8'd1);
    tick();
    drive(rd, 0, 0, 0);
    chk("lu_release", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(nop(), 0, 0, 0);
    chk("lu_fa", 8'(bus.fwd_a_sel), 8'd2);
    chk("lu_fb", 8'(bus.fwd_b_sel), 8'd0);
    tick();
    drain();

    // Taken branch with a load-use candidate in ID: masked, exactly BP bubbles
    drive(mk(1, 1, 0, 0, 7, 1, 1), 0, 0, 0); tick();
    rd = mk(7, 1, 0, 0, 8, 1, 0);
    drive(rd, 1, 0, 0);
    chk("br_flush0", 8'(bus.flush_if_id), 8'd1);
    chk("br_bubble0", 8'(bus.bubble_ex), 8'd1);
    chk("br_masked_stall", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(rd, 0, 0, 0);
    chk("br_flush1", 8'(bus.flush_if_id), 8'd1);
    chk("br_stall1", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(rd, 0, 0, 0);
    chk("br_flush_end", 8'(bus.flush_if_id), 8'd0);
    tick();
    drain();

    // mem_stall for 3 cycles while one flush cycle remains
    drive(nop(), 1, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(nop(), 1, 1, 0);
      chk("ms_stall", 8'(bus.stall_if_id), 8'd1);
      chk("ms_noflush", 8'(bus.flush_if_id), 8'd0);
      tick();
    end
    drive(nop(), 0, 0, 0);
    chk("ms_resume_flush", 8'(bus.flush_if_id), 8'd1);
    tick();
    drive(nop(), 0, 0, 0);
    chk("ms_flush_done", 8'(bus.flush_if_id), 8'd0);
    tick();
    drain();

    // r0 guard: ADD r0 then reader; LW r0 then reader
    drive(mk(1, 1, 1, 1, 0, 1, 0), 0, 0, 0); tick();
    drive(mk(0, 1, 0, 1, 5, 1, 0), 0, 0, 0); tick();
    drive(nop(), 0, 0, 0);
    chk("r0_add_fa", 8'(bus.fwd_a_sel), 8'd0);
    chk("r0_add_fb", 8'(bus.fwd_b_sel), 8'd0);
    tick();
    drive(mk(1, 1, 0, 0, 0, 1, 1), 0, 0, 0); tick();
    drive(mk(0, 1, 0, 1, 5, 1, 0), 0, 0, 0);
    chk("r0_lw_nostall", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(nop(), 0, 0, 0);
    chk("r0_lw_fa", 8'(bus.fwd_a_sel), 8'd0);
    tick();
    drain();

    // Reset mid-flush abandons the flush
    drive(nop(), 1, 0, 0); tick();
    drive(nop(), 0, 0, 1); tick();
    drive(nop(), 0, 0, 0);
    chk("rstfl_flush", 8'(bus.flush_if_id), 8'd0);
    chk("rstfl_bubble", 8'(bus.bubble_ex), 8'd0);
    chk("rstfl_stall", 8'(bus.stall_if_id), 8'd0);
    tick();
    drive(nop(), 0, 0, 0);
    chk("rstfl_noflush", 8'(bus.flush_if_id), 8'd0);
    tick();

    // Random traffic against the model, small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      ins_t x;
      x.v  = ($urandom_range(0, 4) != 0);
      x.we = $urandom_range(0, 1);
      x.wa = $urandom_range(0, 3);
      x.ld = ($urandom_range(0, 2) == 0);
      x.s1 = $urandom_range(0, 3);
      x.e1 = $urandom_range(0, 1);
      x.s2 = $urandom_range(0, 3);
      x.e2 = $urandom_range(0, 1);
      drive(x, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the uDLX ID/EX/MEM/WB pipeline.
- Consumes the decoded register and memory controls for the instruction in ID.
- Tracks in-flight register writes in EX, MEM and WB shadow slots.
- Generates load-use stalls, taken-branch/jump flush bubbles, memory-wait freezes and operand forwarding selects for the instruction in EX.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- BRANCH_PENALTY, 2, bubble cycles after a taken branch/jump; legal range 1..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- id_valid  input  1  ID holds a real (non-NOP) instruction.
- id_rd_addr1  input  REG_ADDR_WIDTH  ID source register 1.
- id_rd_en1  input  1  ID reads source 1.
- id_rd_addr2  input  REG_ADDR_WIDTH  ID source register 2.
- id_rd_en2  input  1  ID reads source 2.
- id_wr_addr  input  REG_ADDR_WIDTH  ID destination register.
- id_wr_en  input  1  ID writes destination.
- id_mem_rd_en  input  1  ID instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- mem_stall  input  1  data memory not ready; freeze the pipeline.
- stall_if_id  output  1  hold PC and the IF/ID register.
- bubble_ex  output  1  load NOP into ID/EX instead of the ID instruction.
- flush_if_id  output  1  clear the IF/ID register.
- fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB result.
- fwd_b_sel  output  2  EX operand B source, same encoding.

Behaviour:
- Shadow slots: EX holds {valid, wr_en, wr_addr, is_load, src1, src1_en, src2, src2_en}; MEM and WB hold {valid, wr_en, wr_addr}.
- A slot "writes r" iff valid & wr_en & (wr_addr == r) & (r != 0).
- Reset (rst=1 at clk edge): all slots invalid, FSM=RUN, penalty counter=0. All outputs read 0 in the following cycle. Reset mid-flush or mid-stall abandons the operation.
- Priority, highest first: mem_stall, ex_branch_taken (in RUN), FLUSH state, load-use hazard, normal.
- mem_stall=1:
  - stall_if_id=1, bubble_ex=0, flush_if_id=0.
  - Slots, FSM and counter hold. ex_branch_taken is ignored; EX is frozen, so the source re-presents it.
- Taken branch (RUN & ex_branch_taken):
  - flush_if_id=1 and bubble_ex=1 the same cycle; stall_if_id=0.
  - If BRANCH_PENALTY>1: counter <= BRANCH_PENALTY-1, FSM -> FLUSH.
- FLUSH:
  - flush_if_id=1, bubble_ex=1, counter decrements each non-stalled cycle.
  - FSM -> RUN on the cycle counter==1 is consumed.
  - ex_branch_taken is ignored, since EX holds a bubble.
  - Total bubble cycles = BRANCH_PENALTY.
- Load-use (RUN, no higher event):
  - Hazard when id_valid & EX.is_load & EX writes r, for r = id_rd_addr1 with id_rd_en1, or r = id_rd_addr2 with id_rd_en2.
  - Response: stall_if_id=1, bubble_ex=1 for exactly 1 cycle. The load then moves to MEM and the hazard clears combinationally.
- Slot advance on every edge without mem_stall:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble if bubble_ex or !id_valid; otherwise the ID fields.
- Forwarding (combinational from slots):
  - fwd_a_sel = 01 if MEM writes EX.src1 (with src1_en); else 10 if WB writes EX.src1; else 00.
  - fwd_b_sel is the same using src2.
  - MEM has priority over WB.
  - r0 is never forwarded.
  - Selects are 00 when EX is invalid.
- Outputs stall_if_id, bubble_ex and flush_if_id are combinational from state and inputs. No same-cycle dependency exists on any output.

Test Plan:
1. Reset mid-flush: taken branch with BRANCH_PENALTY=2, rst on the next edge -> all outputs 0 and FSM RUN the cycle after; no further flush.
2. Forwarding chain: ADD r3 (wr r3), then ADD r4=r3+r3, then SUB r5=r3+r4 -> cycle 2 fwd_a_sel=fwd_b_sel=01; cycle 3 fwd_a_sel=10, fwd_b_sel=01; no stalls.
3. Load-use: LW r2, then ADD r6=r2+r1 -> one cycle of stall_if_id=1 & bubble_ex=1; then ADD in EX with fwd_a_sel=10, fwd_b_sel=00.
4. Taken branch, BRANCH_PENALTY=2: ex_branch_taken pulse -> flush_if_id & bubble_ex high exactly 2 cycles, stall_if_id=0; a load-use hazard in ID during the flush is masked.
5. mem_stall for 3 cycles during FLUSH (counter=1) -> stall_if_id=1, flush=0, slots frozen; after release, 1 remaining flush cycle.
6. r0 guard: ADD r0 followed by a reader of r0, and LW r0 followed by a reader of r0 -> fwd selects 00, no stall.
